// File: rtl/wb_queue.sv
// Write-back queue: a small circular FIFO of pending register-file writes.
// The head entry drains into the register file whenever it is not stalled.
// Operand reads are forwarded from the youngest matching pending entry, so
// consumers never see a stale register-file value.
module wb_queue #(
   parameter int WORD_SIZE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [4:0]                i_rd,
   input  logic [WORD_SIZE-1:0]      i_data,
   input  logic                      i_stall,
   output logic                      o_Wen,
   output logic [4:0]                o_Wnum,
   output logic [WORD_SIZE-1:0]      o_Wd,
   input  logic [4:0]                i_Rnum1,
   input  logic [4:0]                i_Rnum2,
   input  logic [WORD_SIZE-1:0]      i_RfRd1,
   input  logic [WORD_SIZE-1:0]      i_RfRd2,
   output logic [WORD_SIZE-1:0]      o_Rd1,
   output logic [WORD_SIZE-1:0]      o_Rd2,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [4:0]           rd_q   [DEPTH];
   logic [WORD_SIZE-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic accept;
   logic store;
   logic pop;

   // Handshake and drain qualifiers; a reset cycle neither stores nor writes.
   always_comb begin
      o_ready = (count_q != FULL_COUNT);
      accept  = i_valid & o_ready & ~i_rst;
      store   = accept & (i_rd != 5'd0);
      o_Wen   = (count_q != '0) & ~i_stall & ~i_rst;
      pop     = o_Wen;
      o_Wnum  = rd_q[head_q];
      o_Wd    = data_q[head_q];
      o_count = count_q;
   end

   // Next-state for pointers and occupancy; wrap is implicit in the pointer width.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (store) tail_d = tail_q + 1'b1;
      if (pop)   head_d = head_q + 1'b1;
      case ({store, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; writes at the tail slot on a storing accept.
   // NOTE: the entry array is deliberately not reset -- validity comes from
   // count_q and head_q, so clearing the RAM would only add reset fan-out.
   always_ff @(posedge i_clk) begin
      if (store) begin
         rd_q[tail_q]   <= i_rd;
         data_q[tail_q] <= i_data;
      end
   end

   // Walk entries oldest to youngest so the last match (the youngest) wins.
   function automatic logic [WORD_SIZE-1:0] forward(input logic [4:0]           rnum,
                                                    input logic [WORD_SIZE-1:0] rf_data);
      logic [WORD_SIZE-1:0] res;
      logic [PTR_W-1:0]     idx;
      res = rf_data;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (rd_q[idx] == rnum)) res = data_q[idx];
      end
      if (rnum == 5'd0) res = '0;
      return res;
   endfunction

   // Zero-cycle operand forwarding for both read ports.
   always_comb begin
      o_Rd1 = forward(i_Rnum1, i_RfRd1);
      o_Rd2 = forward(i_Rnum2, i_RfRd2);
   end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (WORD_SIZE=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled once
// the combinational logic has settled, well before the next edge.
module tb_wb_queue;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [4:0]  i_rd;
   logic [31:0] i_data;
   logic        i_stall;
   logic        o_Wen;
   logic [4:0]  o_Wnum;
   logic [31:0] o_Wd;
   logic [4:0]  i_Rnum1, i_Rnum2;
   logic [31:0] i_RfRd1, i_RfRd2;
   logic [31:0] o_Rd1, o_Rd2;
   logic [2:0]  o_count;

   int n_cmp = 0;
   int n_err = 0;

   wb_queue #(.WORD_SIZE(32), .DEPTH(4)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_rd    (i_rd),
      .i_data  (i_data),
      .i_stall (i_stall),
      .o_Wen   (o_Wen),
      .o_Wnum  (o_Wnum),
      .o_Wd    (o_Wd),
      .i_Rnum1 (i_Rnum1),
      .i_Rnum2 (i_Rnum2),
      .i_RfRd1 (i_RfRd1),
      .i_RfRd2 (i_RfRd2),
      .o_Rd1   (o_Rd1),
      .o_Rd2   (o_Rd2),
      .o_count (o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      i_valid = 1'b1; i_rd = rd; i_data = data;
      step();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      i_Rnum1 = 5'd3; i_RfRd1 = 32'h0000_AAAA;
      i_Rnum2 = 5'd0; i_RfRd2 = 32'h0000_0005;
      #1;
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", o_count); end
      n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
      n_cmp++; if (o_Wen !== 1'b0) begin n_err++; $display("FAIL rst_wen got=%b exp=0", o_Wen); end
      n_cmp++; if (o_Rd1 !== 32'h0000_AAAA) begin n_err++; $display("FAIL rst_rd1 got=%h exp=0000aaaa", o_Rd1); end
      n_cmp++; if (o_Rd2 !== 32'h0) begin n_err++; $display("FAIL rst_rd2_x0 got=%h exp=0", o_Rd2); end
   endtask

   task automatic test_single();
      push(5'd5, 32'hDEAD_BEEF);
      #1;
      n_cmp++; if (o_Wen !== 1'b1) begin n_err++; $display("FAIL single_wen got=%b exp=1", o_Wen); end
      n_cmp++; if (o_Wnum !== 5'd5) begin n_err++; $display("FAIL single_wnum got=%0d exp=5", o_Wnum); end
      n_cmp++; if (o_Wd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wd got=%h exp=deadbeef", o_Wd); end
      n_cmp++; if (o_count !== 3'd1) begin n_err++; $display("FAIL single_count1 got=%0d exp=1", o_count); end
      step();
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL single_count0 got=%0d exp=0", o_count); end
      n_cmp++; if (o_Wen !== 1'b0) begin n_err++; $display("FAIL single_wen0 got=%b exp=0", o_Wen); end
   endtask

   task automatic test_full_stall();
      i_stall = 1'b1;
      for (int k = 1; k <= 4; k++) push(5'(k), 32'(k * 256));
      #1;
      n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d exp=4", o_count); end
      n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", o_ready); end
      n_cmp++; if (o_Wen !== 1'b0) begin n_err++; $display("FAIL full_wen_stalled got=%b exp=0", o_Wen); end
      push(5'd9, 32'h0000_0999);
      #1;
      n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL full_5th_count got=%0d exp=4", o_count); end
      i_stall = 1'b0;
      #1;
      for (int k = 1; k <= 4; k++) begin
         n_cmp++; if (o_Wen !== 1'b1 || o_Wnum !== 5'(k) || o_Wd !== 32'(k * 256)) begin
            n_err++; $display("FAIL full_drain%0d got wen=%b num=%0d wd=%h exp wen=1 num=%0d wd=%h", k, o_Wen, o_Wnum, o_Wd, k, k * 256);
         end
         step();
      end
      n_cmp++; if (o_count !== 3'd0 || o_Wen !== 1'b0) begin n_err++; $display("FAIL full_empty got count=%0d wen=%b exp 0/0", o_count, o_Wen); end
   endtask

   task automatic test_forward();
      i_stall = 1'b1;
      push(5'd7, 32'h11);
      push(5'd7, 32'h22);
      i_Rnum1 = 5'd7; i_RfRd1 = 32'h99;
      #1;
      n_cmp++; if (o_Rd1 !== 32'h22) begin n_err++; $display("FAIL fwd_youngest got=%h exp=22", o_Rd1); end
      i_valid = 1'b1; i_rd = 5'd7; i_data = 32'h33;
      #1;
      n_cmp++; if (o_Rd1 !== 32'h22) begin n_err++; $display("FAIL fwd_no_incoming got=%h exp=22", o_Rd1); end
      i_valid = 1'b0;
      i_stall = 1'b0;
      #1;
      n_cmp++; if (o_Wen !== 1'b1 || o_Wd !== 32'h11) begin n_err++; $display("FAIL fwd_head got wen=%b wd=%h exp 1/11", o_Wen, o_Wd); end
      step();
      n_cmp++; if (o_Rd1 !== 32'h22 || o_count !== 3'd1) begin n_err++; $display("FAIL fwd_head_writing got rd1=%h count=%0d exp 22/1", o_Rd1, o_count); end
      step();
      n_cmp++; if (o_Rd1 !== 32'h99 || o_count !== 3'd0) begin n_err++; $display("FAIL fwd_drained got rd1=%h count=%0d exp 99/0", o_Rd1, o_count); end
   endtask

   task automatic test_rd_zero();
      i_valid = 1'b1; i_rd = 5'd0; i_data = 32'h1234;
      #1;
      n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%b exp=1", o_ready); end
      step();
      i_valid = 1'b0;
      i_Rnum2 = 5'd0; i_RfRd2 = 32'h5555;
      #1;
      n_cmp++; if (o_count !== 3'd0 || o_Wen !== 1'b0) begin n_err++; $display("FAIL x0_discard got count=%0d wen=%b exp 0/0", o_count, o_Wen); end
      n_cmp++; if (o_Rd2 !== 32'h0) begin n_err++; $display("FAIL x0_rd2 got=%h exp=0", o_Rd2); end
   endtask

   task automatic test_full_pop();
      logic [4:0] exp_rd [4];
      exp_rd[0] = 5'd2; exp_rd[1] = 5'd3; exp_rd[2] = 5'd4; exp_rd[3] = 5'd10;
      i_stall = 1'b1;
      for (int k = 1; k <= 4; k++) push(5'(k), 32'(k));
      i_stall = 1'b0;
      i_valid = 1'b1; i_rd = 5'd10; i_data = 32'hA;
      #1;
      n_cmp++; if (o_Wen !== 1'b1 || o_ready !== 1'b0) begin n_err++; $display("FAIL fp_pop_full got wen=%b ready=%b exp 1/0", o_Wen, o_ready); end
      step();
      i_stall = 1'b1;
      #1;
      n_cmp++; if (o_count !== 3'd3 || o_ready !== 1'b1) begin n_err++; $display("FAIL fp_no_accept got count=%0d ready=%b exp 3/1", o_count, o_ready); end
      step();
      i_valid = 1'b0;
      #1;
      n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL fp_accept got count=%0d exp=4", o_count); end
      i_stall = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (o_Wen !== 1'b1 || o_Wnum !== exp_rd[k]) begin
            n_err++; $display("FAIL fp_drain%0d got wen=%b num=%0d exp 1/%0d", k, o_Wen, o_Wnum, exp_rd[k]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      i_stall = 1'b1;
      push(5'd11, 32'hB);
      push(5'd12, 32'hC);
      push(5'd13, 32'hD);
      #1;
      n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL rm_pending got count=%0d exp=3", o_count); end
      i_rst = 1'b1; i_stall = 1'b0; i_valid = 1'b1; i_rd = 5'd14; i_data = 32'hE;
      #1;
      n_cmp++; if (o_Wen !== 1'b0) begin n_err++; $display("FAIL rm_wen_in_rst got=%b exp=0", o_Wen); end
      step();
      i_rst = 1'b0; i_valid = 1'b0;
      #1;
      n_cmp++; if (o_count !== 3'd0 || o_Wen !== 1'b0) begin n_err++; $display("FAIL rm_cleared got count=%0d wen=%b exp 0/0", o_count, o_Wen); end
      for (int k = 0; k < 6; k++) begin
         i_valid = 1'b1; i_rd = 5'(16 + k); i_data = 32'(32'h100 + k);
         #1;
         if (k > 0) begin
            n_cmp++; if (o_Wen !== 1'b1 || o_Wnum !== 5'(15 + k) || o_Wd !== 32'(32'h100 + k - 1) || o_count !== 3'd1) begin
               n_err++; $display("FAIL rm_wrap%0d got wen=%b num=%0d wd=%h count=%0d exp 1/%0d/%h/1", k, o_Wen, o_Wnum, o_Wd, o_count, 15 + k, 32'h100 + k - 1);
            end
         end
         step();
      end
      i_valid = 1'b0;
      #1;
      n_cmp++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd21 || o_Wd !== 32'h105) begin n_err++; $display("FAIL rm_last got wen=%b num=%0d wd=%h exp 1/21/105", o_Wen, o_Wnum, o_Wd); end
      step();
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rm_final got count=%0d exp=0", o_count); end
   endtask

   initial begin
      i_rst = 1'b0; i_valid = 1'b0; i_rd = '0; i_data = '0; i_stall = 1'b0;
      i_Rnum1 = '0; i_Rnum2 = '0; i_RfRd1 = '0; i_RfRd2 = '0;
      #1;
      test_reset();
      test_single();
      test_full_stall();
      test_forward();
      test_rd_zero();
      test_full_pop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
